// File: rtl/mul_pkg.sv
// Shared encodings and defaults for the shift-add multiply sequencer.
//   MulOp encodings, FSM state encodings, default operand width.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;

    // Multiply operation select; 2'b11 is reserved and executes as MUL.
    typedef enum logic [1:0] {
        MULOP_MUL   = 2'b00,
        MULOP_UMULL = 2'b01,
        MULOP_SMULL = 2'b10,
        MULOP_RSVD  = 2'b11
    } mulOpT;

    // Sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } stateT;

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/response bundle between the core control FSM and the multiplier.
//   Start/MulOp/SrcA/SrcB : request (master -> slave)
//   Busy/Done/ResultLo/ResultHi : status and product (slave -> master)
interface mul_sequencer_if
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
);
    logic             Start;
    logic [1:0]       MulOp;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ResultLo;
    logic [WIDTH-1:0] ResultHi;

    modport master (
        output Start, MulOp, SrcA, SrcB,
        input  Busy, Done, ResultLo, ResultHi
    );

    modport slave (
        input  Start, MulOp, SrcA, SrcB,
        output Busy, Done, ResultLo, ResultHi
    );
endinterface

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: operand magnitude capture, one add/shift
// iteration per step strobe, sign fix-up and result load on the fix strobe.
//   clk, reset        : clock, async active-high reset
//   load/step/fix     : control strobes from the sequencer
//   op, srcA, srcB    : operation and operands, captured on load
//   resultLo/resultHi : registered product halves, updated on fix only
module mul_shift_add_dp
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  mulOpT            op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] resultLo,
    output logic [WIDTH-1:0] resultHi
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = PW + 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [AW-1:0]    acc;
    logic             negRes;
    logic             longOp;

    logic             isSmull;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   upperSum;
    logic [PW-1:0]    fixed;

    // Magnitudes are unsigned, so abs of the most-negative value is exact.
    always_comb begin
        isSmull  = (op == MULOP_SMULL);
        absA     = (isSmull && srcA[WIDTH-1]) ? (~srcA + WIDTH'(1)) : srcA;
        absB     = (isSmull && srcB[WIDTH-1]) ? (~srcB + WIDTH'(1)) : srcB;
        upperSum = acc[AW-1:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
        fixed    = negRes ? (~acc[PW-1:0] + PW'(1)) : acc[PW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            negRes   <= 1'b0;
            longOp   <= 1'b0;
            resultLo <= '0;
            resultHi <= '0;
        end else begin
            if (load) begin
                mcand  <= absA;
                mplier <= absB;
                acc    <= '0;
                negRes <= isSmull & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                longOp <= (op == MULOP_UMULL) || (op == MULOP_SMULL);
            end
            // Add into the upper half, then shift {carry,acc} right by one.
            if (step) begin
                acc    <= {1'b0, upperSum, acc[WIDTH-1:1]};
                mplier <= mplier >> 1;
            end
            if (fix) begin
                resultLo <= fixed[WIDTH-1:0];
                resultHi <= longOp ? fixed[PW-1:WIDTH] : '0;
            end
        end
    end
endmodule

// File: rtl/mul_sequencer.sv
// Iterative multiply unit: IDLE -> RUN (WIDTH iterations) -> FIX -> DONE.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of mul_sequencer_if (Start/MulOp/SrcA/SrcB in,
//                Busy/Done/ResultLo/ResultHi out)
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNTW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    mul_sequencer_if.slave  bus
);
    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);

    stateT           state;
    stateT           nextState;
    logic [CNTW-1:0] counter;
    logic            busyQ;
    logic            doneQ;
    logic            load;
    logic            step;
    logic            fix;
    logic [WIDTH-1:0] resultLo;
    logic [WIDTH-1:0] resultHi;

    // State, iteration counter and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            counter <= '0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            state <= nextState;
            busyQ <= (nextState != S_IDLE);
            doneQ <= (nextState == S_DONE);
            if (load) begin
                counter <= '0;
            end else if (step) begin
                counter <= counter + CNTW'(1);
            end
        end
    end

    // Next-state and datapath strobes; Start is only looked at in IDLE.
    always_comb begin
        nextState = state;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.Start) begin
                    load      = 1'b1;
                    nextState = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (counter == LAST_ITER) begin
                    nextState = S_FIX;
                end
            end
            S_FIX: begin
                fix       = 1'b1;
                nextState = S_DONE;
            end
            S_DONE: begin
                nextState = S_IDLE;
            end
            default: begin
                nextState = S_IDLE;
            end
        endcase
    end

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .fix      (fix),
        .op       (mulOpT'(bus.MulOp)),
        .srcA     (bus.SrcA),
        .srcB     (bus.SrcB),
        .resultLo (resultLo),
        .resultHi (resultHi)
    );

    assign bus.Busy     = busyQ;
    assign bus.Done     = doneQ;
    assign bus.ResultLo = resultLo;
    assign bus.ResultHi = resultHi;
endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: table of directed vectors, random
// vectors against a reference product, and hand-written corner sequences
// (held Start, mid-operation reset, result holding). Expected results go
// into a scoreboard queue at launch and are popped when Done appears.
module tb_mul_sequencer;
    import mul_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mul_sequencer_if #(.WIDTH(W)) bus();

    mul_sequencer #(.WIDTH(W), .CNTW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expLo;
        logic [W-1:0] expHi;
        string        name;
    } vecT;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
    } expT;

    vecT tbl[12];
    expT sb[$];
    int  nVec = 0;
    int  nErr = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] refProd(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        logic [63:0] p;
        case (op)
            2'b01:   p = {32'b0, a} * {32'b0, b};
            2'b10:   p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
            default: p = {32'b0, 32'(a * b)};
        endcase
        return p;
    endfunction

    // Waits for Done at negedges; lat counts clock edges since the accepting edge.
    task automatic waitDone(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            seen = bus.Done;
        end
    endtask

    // Issue one operation from a negedge and check it through to Done.
    task automatic runOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expLo, input logic [W-1:0] expHi,
                         input string name);
        int  lat;
        bit  seen;
        expT e;
        lat = 0;
        while (bus.Busy && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        bus.Start = 1'b1;
        bus.MulOp = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        e.lo = expLo;
        e.hi = expHi;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.Start = 1'b0;
        bus.SrcA  = $urandom;
        bus.SrcB  = $urandom;
        bus.MulOp = 2'($urandom);
        check({name, " busy"}, 64'(bus.Busy), 64'd1);
        waitDone(lat, seen);
        check({name, " latency"}, 64'(lat), 64'(W + 1));
        e = sb.pop_front();
        if (seen) begin
            check({name, " lo"}, 64'(bus.ResultLo), 64'(e.lo));
            check({name, " hi"}, 64'(bus.ResultHi), 64'(e.hi));
        end
        @(negedge clk);
        check({name, " done width"}, 64'(bus.Done), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  lat;
        bit  seen;
        bit  changed;
        int  doneCnt;
        expT e;
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [63:0]  rp;

        tbl[0]  = '{2'b00, 32'd5,          32'd8,          32'h0000_0028, 32'h0000_0000, "mul 5x8"};
        tbl[1]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 32'hFFFF_FFFE, "umull max"};
        tbl[2]  = '{2'b10, 32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB, 32'hFFFF_FFFF, "smull -3x7"};
        tbl[3]  = '{2'b10, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000, 32'h4000_0000, "smull minxmin"};
        tbl[4]  = '{2'b00, 32'd0,          32'h1234_5678,  32'h0000_0000, 32'h0000_0000, "mul 0xN"};
        tbl[5]  = '{2'b11, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE, 32'h0000_0000, "reserved op"};
        tbl[6]  = '{2'b01, 32'h8000_0000,  32'd2,          32'h0000_0000, 32'h0000_0001, "umull carry"};
        tbl[7]  = '{2'b10, 32'hFFFF_FFFF,  32'h8000_0000,  32'h8000_0000, 32'h0000_0000, "smull -1xmin"};
        tbl[8]  = '{2'b10, 32'h7FFF_FFFF,  32'h8000_0000,  32'h8000_0000, 32'hC000_0000, "smull maxxmin"};
        tbl[9]  = '{2'b00, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 32'h0000_0000, "mul hi dropped"};
        tbl[10] = '{2'b10, 32'd5,          32'd6,          32'h0000_001E, 32'h0000_0000, "smull 5x6"};
        tbl[11] = '{2'b10, 32'd7,          32'hFFFF_FFFD,  32'hFFFF_FFEB, 32'hFFFF_FFFF, "smull 7x-3"};

        bus.Start = 1'b0;
        bus.MulOp = 2'b00;
        bus.SrcA  = '0;
        bus.SrcB  = '0;

        // Reset state.
        #2 reset = 1'b1;
        #1;
        check("reset busy", 64'(bus.Busy), 64'd0);
        check("reset done", 64'(bus.Done), 64'd0);
        check("reset lo",   64'(bus.ResultLo), 64'd0);
        check("reset hi",   64'(bus.ResultHi), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            runOp(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].expLo, tbl[i].expHi, tbl[i].name);
        end

        // Random vectors against the reference product.
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            rp  = refProd(rop, ra, rb);
            runOp(rop, ra, rb, rp[31:0], rp[63:32], "random");
        end

        // Result holding after Done.
        runOp(2'b00, 32'h1234_5678, 32'd1, 32'h1234_5678, 32'h0, "mul Nx1");
        changed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ResultLo !== 32'h1234_5678 || bus.ResultHi !== 32'h0) changed = 1'b1;
        end
        check("hold 20 idle cycles", 64'(changed), 64'd0);

        // Start held high with changing operand through RUN and Done.
        bus.Start = 1'b1;
        bus.MulOp = 2'b00;
        bus.SrcA  = 32'd6;
        bus.SrcB  = 32'd7;
        e.lo = 32'h2A;
        e.hi = 32'h0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.SrcA = 32'd9;
        check("held busy", 64'(bus.Busy), 64'd1);
        waitDone(lat, seen);
        doneCnt = seen ? 1 : 0;
        check("held latency", 64'(lat), 64'(W + 1));
        e = sb.pop_front();
        check("held lo", 64'(bus.ResultLo), 64'(e.lo));
        check("held hi", 64'(bus.ResultHi), 64'(e.hi));
        @(negedge clk);
        if (bus.Done) doneCnt++;
        check("held done count", 64'(doneCnt), 64'd1);
        check("held back to idle", 64'(bus.Busy), 64'd0);
        bus.Start = 1'b0;
        runOp(2'b00, 32'd9, 32'd7, 32'd63, 32'd0, "restart");

        // Reset in the middle of RUN.
        bus.Start = 1'b1;
        bus.MulOp = 2'b01;
        bus.SrcA  = 32'h1234;
        bus.SrcB  = 32'h5678;
        @(posedge clk);
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset busy", 64'(bus.Busy), 64'd0);
        check("midreset done", 64'(bus.Done), 64'd0);
        check("midreset lo",   64'(bus.ResultLo), 64'd0);
        check("midreset hi",   64'(bus.ResultHi), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Done || bus.Busy) doneCnt++;
        end
        check("no activity after reset", 64'(doneCnt), 64'd0);
        runOp(2'b00, 32'd3, 32'd3, 32'd9, 32'd0, "post-reset 3x3");

        check("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
